alu_issue_stage: RTL and testbench

//  Decode/issue stage driving the ALU: accepts one fetched RV32I instruction plus register-file

---
 rtl/alu_issue_pkg.sv | 58 +++++
 rtl/alu_issue_decode.sv | 114 +++++++++++
 rtl/alu_issue_stage.sv | 129 ++++++++++++
 tb/tb_alu_issue_stage.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, ALU_Control layout, FSM states, payload.
// The payload carries an illegal flag only when ALU_ISSUE_ILLEGAL_EN is defined.
package alu_issue_pkg;

    localparam int XLEN_C = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [1:0] CLS_BASE   = 2'b00;
    localparam logic [1:0] CLS_ALT    = 2'b01;
    localparam logic [1:0] CLS_BRANCH = 2'b10;
    localparam logic [1:0] CLS_PASS   = 2'b11;

    localparam int CTRL_MEM_BIT = 5;
    localparam int CTRL_CLS_LSB = 3;
    localparam int CTRL_F3_LSB  = 0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [5:0]        alu_ctrl;
        logic              branch_op;
        logic [XLEN_C-1:0] op_a;
        logic [XLEN_C-1:0] op_b;
        logic [XLEN_C-1:0] imm;
        logic [XLEN_C-1:0] pc;
        logic [4:0]        rd;
        logic              reg_write;
`ifdef ALU_ISSUE_ILLEGAL_EN
        logic              illegal;
`endif
    } payload_t;

    localparam int PAYLOAD_W = $bits(payload_t);

    function automatic logic [5:0] make_ctrl(input logic mem, input logic [1:0] cls,
                                             input logic [2:0] f3);
        logic [5:0] c;
        c = '0;
        c[CTRL_MEM_BIT] = mem;
        c[CTRL_CLS_LSB +: 2] = cls;
        c[CTRL_F3_LSB +: 3] = f3;
        return c;
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode of one instruction plus register data into an issue payload.
// Exports the illegal flag in the payload when ALU_ISSUE_ILLEGAL_EN is defined.
module alu_issue_decode
    import alu_issue_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic [31:0]          instr,
    input  logic [31:0]          pc,
    input  logic [31:0]          rs1_data,
    input  logic [31:0]          rs2_data,
    output logic [PAYLOAD_W-1:0] payload
);

    logic        illegal;
    logic [31:0] word;
    logic [31:0] a_src;
    logic [31:0] b_src;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    payload_t    p;

    always_comb begin
        case (instr[6:0])
            OPC_OP:     illegal = !(instr[31:25] == 7'b0000000 || instr[31:25] == 7'b0100000);
            OPC_OPIMM, OPC_BRANCH, OPC_JAL, OPC_JALR,
            OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE:
                        illegal = 1'b0;
            default:    illegal = 1'b1;
        endcase
    end

    // Substituted NOP reads x0, so its register operands are zero rather than the raw read data.
    assign word  = illegal ? NOP_INSTR : instr;
    assign a_src = illegal ? 32'd0 : rs1_data;
    assign b_src = illegal ? 32'd0 : rs2_data;

    assign opcode = word[6:0];
    assign f3     = word[14:12];
    assign imm_i  = {{20{word[31]}}, word[31:20]};
    assign imm_s  = {{20{word[31]}}, word[31:25], word[11:7]};
    assign imm_b  = {{20{word[31]}}, word[7], word[30:25], word[11:8], 1'b0};
    assign imm_j  = {{12{word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
    assign imm_u  = {word[31:12], 12'd0};

    always_comb begin
        p    = '0;
        p.pc = pc;
        p.rd = word[11:7];
        case (opcode)
            OPC_OP: begin
                p.alu_ctrl  = make_ctrl(1'b0, (word[30] && (f3 == 3'b000 || f3 == 3'b101))
                                        ? CLS_ALT : CLS_BASE, f3);
                p.op_a      = a_src;
                p.op_b      = b_src;
                p.reg_write = 1'b1;
            end
            OPC_OPIMM: begin
                p.alu_ctrl  = make_ctrl(1'b0, (f3 == 3'b101 && word[30]) ? CLS_ALT : CLS_BASE, f3);
                p.op_a      = a_src;
                p.op_b      = (f3 == 3'b001 || f3 == 3'b101) ? {27'd0, imm_i[4:0]} : imm_i;
                p.imm       = imm_i;
                p.reg_write = 1'b1;
            end
            OPC_BRANCH: begin
                p.alu_ctrl  = make_ctrl(1'b0, CLS_BRANCH, f3);
                p.branch_op = 1'b1;
                p.op_a      = a_src;
                p.op_b      = b_src;
                p.imm       = imm_b;
            end
            OPC_JAL, OPC_JALR: begin
                p.alu_ctrl  = make_ctrl(1'b0, CLS_PASS, 3'b000);
                p.op_a      = pc + 32'd4;
                p.imm       = (opcode == OPC_JAL) ? imm_j : imm_i;
                p.reg_write = 1'b1;
            end
            OPC_LUI: begin
                p.alu_ctrl  = make_ctrl(1'b0, CLS_PASS, 3'b000);
                p.op_a      = imm_u;
                p.imm       = imm_u;
                p.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                p.op_a      = pc;
                p.op_b      = imm_u;
                p.imm       = imm_u;
                p.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                p.alu_ctrl  = make_ctrl(1'b1, CLS_BASE, 3'b000);
                p.op_a      = a_src;
                p.op_b      = imm_i;
                p.imm       = imm_i;
                p.reg_write = 1'b1;
            end
            OPC_STORE: begin
                p.alu_ctrl  = make_ctrl(1'b1, CLS_BASE, 3'b000);
                p.op_a      = a_src;
                p.op_b      = imm_s;
                p.imm       = imm_s;
            end
            default: p.rd = 5'd0;
        endcase
        if (p.rd == 5'd0) p.reg_write = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
        p.illegal = illegal;
`endif
    end

    assign payload = p;

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage with a 2-entry (main + skid) output buffer, 1 instr/cycle throughput.
// Define ALU_ISSUE_ILLEGAL_EN to add the out_illegal port.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      ALU_Control,
    output logic            branch_op,
    output logic [XLEN-1:0] operand_A,
    output logic [XLEN-1:0] operand_B,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic            out_reg_write
`ifdef ALU_ISSUE_ILLEGAL_EN
    ,
    output logic            out_illegal
`endif
);

    state_t   state_q, state_d;
    payload_t dec_p0;
    payload_t main_p0;
    payload_t skid_p0;
    logic     accept, issue;
    logic     ld_main_in, ld_main_skid, ld_skid;

    alu_issue_decode #(
        .NOP_INSTR (NOP_INSTR)
    ) u_decode (
        .instr    (in_instr),
        .pc       (in_pc),
        .rs1_data (in_rs1_data),
        .rs2_data (in_rs2_data),
        .payload  (dec_p0)
    );

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign issue     = out_valid & out_ready;

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        ld_main_in = 1'b1;
                        state_d    = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && issue) begin
                        ld_main_in = 1'b1;
                    end else if (accept) begin
                        ld_skid = 1'b1;
                        state_d = ST_FULL;
                    end else if (issue) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (issue) begin
                        ld_main_skid = 1'b1;
                        state_d      = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload registers are cleared by reset so every output reads zero while in reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            main_p0 <= '0;
            skid_p0 <= '0;
        end else begin
            if (ld_main_in) begin
                main_p0 <= dec_p0;
            end else if (ld_main_skid) begin
                main_p0 <= skid_p0;
            end
            if (ld_skid) begin
                skid_p0 <= dec_p0;
            end
        end
    end

    assign ALU_Control   = main_p0.alu_ctrl;
    assign branch_op     = main_p0.branch_op;
    assign operand_A     = main_p0.op_a;
    assign operand_B     = main_p0.op_b;
    assign out_imm       = main_p0.imm;
    assign out_pc        = main_p0.pc;
    assign out_rd        = main_p0.rd;
    assign out_reg_write = main_p0.reg_write;
`ifdef ALU_ISSUE_ILLEGAL_EN
    assign out_illegal   = main_p0.illegal;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vectors plus a queue scoreboard
// fed by an independent reference decoder. Honours ALU_ISSUE_ILLEGAL_EN.
module tb_alu_issue_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  ALU_Control;
    logic        branch_op;
    logic [31:0] operand_A, operand_B, out_imm, out_pc;
    logic [4:0]  out_rd;
    logic        out_reg_write;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic        out_illegal;
`endif

    typedef struct packed {
        logic [5:0]  ctrl;
        logic        br;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errs   = 0;
    int   n_issued = 0;

    always #5 clock = ~clock;

    alu_issue_stage dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .in_rs1_data   (in_rs1_data),
        .in_rs2_data   (in_rs2_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .ALU_Control   (ALU_Control),
        .branch_op     (branch_op),
        .operand_A     (operand_A),
        .operand_B     (operand_B),
        .out_imm       (out_imm),
        .out_pc        (out_pc),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write)
`ifdef ALU_ISSUE_ILLEGAL_EN
        ,
        .out_illegal   (out_illegal)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ref_model(input logic [31:0] i, input logic [31:0] pc,
                                       input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        logic [2:0]  f3;
        logic [31:0] ii, is, ib, ij, iu;
        f3 = i[14:12];
        ii = {{20{i[31]}}, i[31:20]};
        is = {{20{i[31]}}, i[31:25], i[11:7]};
        ib = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
        ij = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
        iu = {i[31:12], 12'd0};
        e = '0;
        e.pc = pc;
        e.rd = i[11:7];
        case (i[6:0])
            7'h33: begin
                if (i[31:25] == 7'h00 || i[31:25] == 7'h20) begin
                    e.ctrl = {1'b0, ((i[30] == 1'b1) && (f3 == 3'd0 || f3 == 3'd5)) ? 2'b01 : 2'b00, f3};
                    e.a = r1; e.b = r2; e.rw = 1'b1;
                end else e.ill = 1'b1;
            end
            7'h13: begin
                e.ctrl = {1'b0, (f3 == 3'd5 && i[30] == 1'b1) ? 2'b01 : 2'b00, f3};
                e.a = r1; e.imm = ii; e.rw = 1'b1;
                e.b = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, i[24:20]} : ii;
            end
            7'h63: begin e.ctrl = {3'b010, f3}; e.br = 1'b1; e.a = r1; e.b = r2; e.imm = ib; end
            7'h6F: begin e.ctrl = 6'b011000; e.a = pc + 32'd4; e.imm = ij; e.rw = 1'b1; end
            7'h67: begin e.ctrl = 6'b011000; e.a = pc + 32'd4; e.imm = ii; e.rw = 1'b1; end
            7'h37: begin e.ctrl = 6'b011000; e.a = iu; e.imm = iu; e.rw = 1'b1; end
            7'h17: begin e.a = pc; e.b = iu; e.imm = iu; e.rw = 1'b1; end
            7'h03: begin e.ctrl = 6'b100000; e.a = r1; e.b = ii; e.imm = ii; e.rw = 1'b1; end
            7'h23: begin e.ctrl = 6'b100000; e.a = r1; e.b = is; e.imm = is; end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin
            e = '0;
            e.pc = pc;
            e.ill = 1'b1;
        end
        if (e.rd == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    // Scoreboard: accepted instructions are queued, issued ones popped and compared.
    always @(negedge clock) begin
        if (reset || flush) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_issued++;
                if (sbq.size() == 0) begin
                    check("sb_unexpected_issue", 32'd1, 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("sb_ctrl", {26'd0, ALU_Control}, {26'd0, mon_e.ctrl});
                    check("sb_br",   {31'd0, branch_op}, {31'd0, mon_e.br});
                    check("sb_a",    operand_A, mon_e.a);
                    check("sb_b",    operand_B, mon_e.b);
                    check("sb_imm",  out_imm, mon_e.imm);
                    check("sb_pc",   out_pc, mon_e.pc);
                    check("sb_rd",   {27'd0, out_rd}, {27'd0, mon_e.rd});
                    check("sb_rw",   {31'd0, out_reg_write}, {31'd0, mon_e.rw});
`ifdef ALU_ISSUE_ILLEGAL_EN
                    check("sb_ill",  {31'd0, out_illegal}, {31'd0, mon_e.ill});
`endif
                end
            end
            if (in_valid && in_ready)
                sbq.push_back(ref_model(in_instr, in_pc, in_rs1_data, in_rs2_data));
        end
    end

    task automatic drive_one(input logic [31:0] instr, input logic [31:0] pc,
                             input logic [31:0] r1, input logic [31:0] r2);
        @(posedge clock); #1;
        in_valid = 1'b1; in_instr = instr; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [0:10];
        logic [31:0] w;
        ops = '{7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h03, 7'h23, 7'h7F, 7'h0B};
        w = $urandom;
        w[6:0] = ops[$urandom_range(0, 10)];
        if (w[6:0] == 7'h33) begin
            case ($urandom_range(0, 3))
                0, 1: w[31:25] = 7'h00;
                2:    w[31:25] = 7'h20;
                default: ;
            endcase
        end
        return w;
    endfunction

    int base;

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
        repeat (2) @(negedge clock);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        check("rst_ctrl",      {26'd0, ALU_Control}, 32'd0);
        check("rst_a",         operand_A, 32'd0);
        check("rst_pc",        out_pc, 32'd0);
        @(posedge clock); #1 reset = 1'b0;

        drive_one(32'h002081B3, 32'h100, 32'd5, 32'd7);
        check("add_valid", {31'd0, out_valid}, 32'd1);
        check("add_ctrl",  {26'd0, ALU_Control}, 32'h00);
        check("add_a",     operand_A, 32'd5);
        check("add_b",     operand_B, 32'd7);
        check("add_rd",    {27'd0, out_rd}, 32'd3);
        check("add_rw",    {31'd0, out_reg_write}, 32'd1);

        drive_one(32'h402081B3, 32'h104, 32'd9, 32'd4);
        check("sub_ctrl", {26'd0, ALU_Control}, 32'h08);

        drive_one(32'h00209193, 32'h108, 32'd1, 32'hDEAD);
        check("slli_ctrl", {26'd0, ALU_Control}, 32'h01);
        check("slli_b",    operand_B, 32'd2);

        drive_one(32'h00208063, 32'h10C, 32'd3, 32'd3);
        check("beq_ctrl", {26'd0, ALU_Control}, 32'h10);
        check("beq_br",   {31'd0, branch_op}, 32'd1);
        check("beq_rw",   {31'd0, out_reg_write}, 32'd0);
        check("beq_imm",  out_imm, 32'd0);

        drive_one(32'hFFFFFFFF, 32'h110, 32'h55, 32'h66);
        check("bad_ctrl", {26'd0, ALU_Control}, 32'd0);
        check("bad_a",    operand_A, 32'd0);
        check("bad_b",    operand_B, 32'd0);
        check("bad_rw",   {31'd0, out_reg_write}, 32'd0);
`ifdef ALU_ISSUE_ILLEGAL_EN
        check("bad_ill",  {31'd0, out_illegal}, 32'd1);
`endif

        drive_one(32'h008000EF, 32'hFFFFFFFC, 32'd1, 32'd2);
        check("jal_ctrl", {26'd0, ALU_Control}, 32'h18);
        check("jal_a",    operand_A, 32'd0);
        check("jal_imm",  out_imm, 32'd8);

        drive_one(32'h123452B7, 32'h200, 32'd0, 32'd0);
        check("lui_a", operand_A, 32'h12345000);

        // Backpressure: three back-to-back offers, only two fit.
        @(posedge clock); #1;
        out_ready = 1'b0;
        base = n_issued;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_instr = 32'h00100093 + (k << 20); in_pc = 32'h300 + 4 * k;
            in_rs1_data = 32'd10 * k; in_rs2_data = 32'd0;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        @(negedge clock);
        check("bp_in_ready",  {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        check("bp_queued",    sbq.size(), 32'd2);
        check("bp_hold_pc",   out_pc, 32'h300);
        @(posedge clock); #1 out_ready = 1'b1;
        repeat (4) @(negedge clock);
        check("bp_drained", n_issued - base, 32'd2);
        check("bp_sb_empty", sbq.size(), 32'd0);

        // Reset while FULL.
        @(posedge clock); #1 out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500113;
        repeat (2) @(posedge clock);
        #1 in_valid = 1'b0;
        @(negedge clock);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        #2 reset = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_in_ready",  {31'd0, in_ready}, 32'd1);
        @(posedge clock); #1 reset = 1'b0; out_ready = 1'b1;
        base = n_issued;
        repeat (3) @(negedge clock);
        check("arst_no_stale", {31'd0, out_valid}, 32'd0);
        check("arst_no_issue", n_issued - base, 32'd0);

        // Flush overrides a same-cycle accept.
        @(posedge clock); #1 out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00700193;
        @(posedge clock); #1 flush = 1'b1;
        @(posedge clock); #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clock);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready",  {31'd0, in_ready}, 32'd1);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            @(posedge clock); #1;
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            flush       = ($urandom_range(0, 40) == 0);
            in_instr    = rand_instr();
            in_pc       = $urandom;
            in_rs1_data = $urandom;
            in_rs2_data = $urandom;
        end
        @(posedge clock); #1 in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (5) @(negedge clock);
        check("final_sb_empty", sbq.size(), 32'd0);
        check("final_out_valid", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
